// File: rtl/net_loopback.sv
// Store-and-forward loopback: whole packets received on the NIC-transmit
// stream are buffered and replayed unmodified on the NIC-receive stream.
// Packets that do not fit (flit RAM or packet slots) are dropped whole.
module net_loopback #(
  parameter int DEPTH     = 64,  // flit-buffer entries, power of 2, >= 4
  parameter int PKT_DEPTH = 8    // max committed packets not yet fully sent
) (
  input  logic        clock,
  input  logic        reset,
  // NIC-transmit stream, sunk here
  input  logic        net_out_valid,
  output logic        net_out_ready,
  input  logic [63:0] net_out_bits_data,
  input  logic [7:0]  net_out_bits_keep,
  input  logic        net_out_bits_last,
  // NIC-receive stream, sourced here
  output logic        net_in_valid,
  input  logic        net_in_ready,
  output logic [63:0] net_in_bits_data,
  output logic [7:0]  net_in_bits_keep,
  output logic        net_in_bits_last,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;               // extra wrap bit tells full from empty
  localparam int CW = $clog2(PKT_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {RX_ACCEPT, RX_DROP} rx_state_e;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } flit_t;

  flit_t     mem [DEPTH];
  rx_state_e state_q, state_d;
  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      commit_ptr_q, commit_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  cnt_t      pkt_count_q, pkt_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic      out_ready_q, out_ready_d;
  logic      out_valid_q, out_valid_d;
  flit_t     out_flit_q, out_flit_d;

  logic  mem_we;
  flit_t in_flit;
  ptr_t  occupancy;
  logic  full, pkt_full, in_hs, out_hs, commit, release_pkt, load;

  assign in_flit  = '{data: net_out_bits_data, keep: net_out_bits_keep, last: net_out_bits_last};
  assign in_hs    = net_out_valid && out_ready_q;
  assign out_hs   = out_valid_q && net_in_ready;
  // Occupancy counts everything written but not yet moved to the output
  // register, including the uncommitted tail of the packet in flight.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == ptr_t'(DEPTH));
  assign pkt_full  = (pkt_count_q == cnt_t'(PKT_DEPTH));

  // Next-state logic for the receive FSM, pointers, counters and output register.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    out_ready_d  = 1'b1;  // overflow is handled by dropping, never by backpressure
    out_valid_d  = out_valid_q;
    out_flit_d   = out_flit_q;
    mem_we       = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      RX_ACCEPT: begin
        if (in_hs) begin
          if (full || (in_flit.last && pkt_full)) begin
            // Rewind over the partial packet; a dropped last flit ends the packet.
            wr_ptr_d = commit_ptr_q;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            if (!in_flit.last) state_d = RX_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (in_flit.last) begin
              commit_ptr_d = wr_ptr_q + ptr_t'(1);
              commit       = 1'b1;
            end
          end
        end
      end
      RX_DROP: begin
        if (in_hs && in_flit.last) state_d = RX_ACCEPT;
      end
      default: state_d = RX_ACCEPT;
    endcase

    // Output register refills whenever it is empty or being emptied this cycle.
    load = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || net_in_ready);
    if (load) begin
      out_valid_d = 1'b1;
      out_flit_d  = mem[rd_ptr_q[AW-1:0]];
      rd_ptr_d    = rd_ptr_q + ptr_t'(1);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    // A packet slot frees once its last flit has been handed off downstream.
    release_pkt = out_hs && out_flit_q.last;
    if (commit && !release_pkt)      pkt_count_d = pkt_count_q + cnt_t'(1);
    else if (!commit && release_pkt) pkt_count_d = pkt_count_q - cnt_t'(1);
  end

  // Flit RAM write port.
  // NOTE: the RAM has no reset; pointers define which entries are valid, and
  // leaving it unreset lets it map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= in_flit;
  end

  // State registers with asynchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RX_ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      out_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      out_ready_q  <= out_ready_d;
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
    end
  end

  assign net_out_ready    = out_ready_q;
  assign net_in_valid     = out_valid_q;
  assign net_in_bits_data = out_flit_q.data;
  assign net_in_bits_keep = out_flit_q.keep;
  assign net_in_bits_last = out_flit_q.last;
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_net_loopback.sv
// Self-checking bench for net_loopback: directed latency/stall/overflow
// sequences, a table of single-packet cases, and a randomized packet stream
// compared against an expected-flit queue.
module tb_net_loopback;

  localparam int DEPTH     = 64;
  localparam int PKT_DEPTH = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } flit_t;

  typedef struct {
    int len;        // flits in the packet
    int stall;      // cycles net_in_ready is held low after sending
    bit delivered;  // expected to appear on net_in_*
    int drop_inc;   // expected drop_count increment
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        net_out_valid = 1'b0;
  logic        net_out_ready;
  logic [63:0] net_out_bits_data = '0;
  logic [7:0]  net_out_bits_keep = '0;
  logic        net_out_bits_last = 1'b0;
  logic        net_in_valid;
  logic        net_in_ready = 1'b1;
  logic [63:0] net_in_bits_data;
  logic [7:0]  net_in_bits_keep;
  logic        net_in_bits_last;
  logic [15:0] drop_count;

  int    checks = 0;
  int    errors = 0;
  int    exp_drops = 0;
  int    exp_lasts = 0;
  int    rx_lasts = 0;
  bit    rdy_random = 1'b0;
  flit_t exp_q[$];
  flit_t rx_q[$];

  net_loopback #(.DEPTH(DEPTH), .PKT_DEPTH(PKT_DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .net_out_valid     (net_out_valid),
    .net_out_ready     (net_out_ready),
    .net_out_bits_data (net_out_bits_data),
    .net_out_bits_keep (net_out_bits_keep),
    .net_out_bits_last (net_out_bits_last),
    .net_in_valid      (net_in_valid),
    .net_in_ready      (net_in_ready),
    .net_in_bits_data  (net_in_bits_data),
    .net_in_bits_keep  (net_in_bits_keep),
    .net_in_bits_last  (net_in_bits_last),
    .drop_count        (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Random downstream backpressure when enabled.
  always begin
    @(posedge clock);
    #1;
    if (rdy_random) net_in_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: records handshaken flits and checks hold-while-stalled.
  flit_t prev_flit;
  bit    prev_stall = 1'b0;
  always @(negedge clock) begin
    flit_t cur;
    cur = '{data: net_in_bits_data, keep: net_in_bits_keep, last: net_in_bits_last};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 80'(net_in_valid), 80'(1));
        check("hold_bits", 80'(cur), 80'(prev_flit));
      end
      if (net_in_valid && net_in_ready) begin
        rx_q.push_back(cur);
        if (cur.last) rx_lasts++;
      end
      prev_stall = net_in_valid && !net_in_ready;
      prev_flit  = cur;
    end
  end

  task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
    net_out_valid     = 1'b1;
    net_out_bits_data = d;
    net_out_bits_keep = k;
    net_out_bits_last = l;
    tick();
  endtask

  task automatic end_send();
    net_out_valid     = 1'b0;
    net_out_bits_last = 1'b0;
  endtask

  // Sends one packet; if it is expected to survive, its flits join exp_q.
  task automatic send_pkt(input int len, input logic [31:0] base, input bit deliver, input bit bubbles);
    flit_t f;
    check("out_ready_high", 80'(net_out_ready), 80'(1));
    for (int i = 0; i < len; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        net_out_valid = 1'b0;
        tick();
      end
      f.data = {base, 32'(i)};
      f.keep = 8'($urandom_range(1, 255));
      f.last = (i == len - 1);
      if (deliver) exp_q.push_back(f);
      send_flit(f.data, f.keep, f.last);
    end
    end_send();
    if (deliver) exp_lasts++;
  endtask

  // Waits (bounded) for all expected flits, then compares the two streams.
  task automatic drain(input string name);
    int n;
    for (int c = 0; c < 4000 && rx_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    check({name, "_count"}, 80'(rx_q.size()), 80'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(name, 80'(rx_q[i]), 80'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
    rx_lasts  = 0;
    exp_lasts = 0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    check("ready_before_edge", 80'(net_out_ready), 80'(0));
    tick();
    check("ready_after_edge", 80'(net_out_ready), 80'(1));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 1,  stall: 0,  delivered: 1'b1, drop_inc: 0};
    vecs[1] = '{len: 3,  stall: 0,  delivered: 1'b1, drop_inc: 0};
    vecs[2] = '{len: 3,  stall: 10, delivered: 1'b1, drop_inc: 0};
    vecs[3] = '{len: 64, stall: 0,  delivered: 1'b1, drop_inc: 0};  // exactly DEPTH fits
    vecs[4] = '{len: 65, stall: 0,  delivered: 1'b0, drop_inc: 1};  // longer than DEPTH
    vecs[5] = '{len: 2,  stall: 0,  delivered: 1'b1, drop_inc: 0};
    vecs[6] = '{len: 16, stall: 5,  delivered: 1'b1, drop_inc: 0};

    // Reset state
    #2;
    check("rst_out_ready", 80'(net_out_ready), 80'(0));
    check("rst_in_valid", 80'(net_in_valid), 80'(0));
    check("rst_drop", 80'(drop_count), 80'(0));
    tick();
    tick();
    release_reset();

    // Latency: 3-flit packet, first flit valid after the edge following commit
    net_in_ready = 1'b1;
    send_flit(64'h11, 8'hFF, 1'b0);
    send_flit(64'h22, 8'hFF, 1'b0);
    send_flit(64'h33, 8'hFF, 1'b1);
    end_send();
    check("lat_E_valid", 80'(net_in_valid), 80'(0));
    tick();
    check("lat_E1_valid", 80'(net_in_valid), 80'(1));
    check("lat_f0", 80'({net_in_bits_data, net_in_bits_keep, net_in_bits_last}), 80'({64'h11, 8'hFF, 1'b0}));
    tick();
    check("lat_f1", 80'({net_in_valid, net_in_bits_data, net_in_bits_last}), 80'({1'b1, 64'h22, 1'b0}));
    tick();
    check("lat_f2", 80'({net_in_valid, net_in_bits_data, net_in_bits_last}), 80'({1'b1, 64'h33, 1'b1}));
    tick();
    check("lat_idle", 80'(net_in_valid), 80'(0));
    rx_q.delete();

    // Stall: flit 0x11 held for 10 cycles, then the rest on release
    net_in_ready = 1'b0;
    send_flit(64'h11, 8'hFF, 1'b0);
    send_flit(64'h22, 8'hFF, 1'b0);
    send_flit(64'h33, 8'hFF, 1'b1);
    end_send();
    exp_q.push_back('{data: 64'h11, keep: 8'hFF, last: 1'b0});
    exp_q.push_back('{data: 64'h22, keep: 8'hFF, last: 1'b0});
    exp_q.push_back('{data: 64'h33, keep: 8'hFF, last: 1'b1});
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", 80'({net_in_valid, net_in_bits_data}), 80'({1'b1, 64'h11}));
      tick();
    end
    net_in_ready = 1'b1;
    drain("stall_stream");
    check("stall_drop", 80'(drop_count), 80'(exp_drops));

    // Table of single-packet cases
    foreach (vecs[v]) begin
      net_in_ready = (vecs[v].stall == 0);
      send_pkt(vecs[v].len, 32'(v + 16'h100), vecs[v].delivered, 1'b0);
      if (!vecs[v].delivered) check("vec_no_valid", 80'(net_in_valid), 80'(0));
      repeat (vecs[v].stall) tick();
      net_in_ready = 1'b1;
      exp_drops += vecs[v].drop_inc;
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_drop", v), 80'(drop_count), 80'(exp_drops));
    end

    // RAM overflow: 40 then 30 then 20 flits with the output stalled
    net_in_ready = 1'b0;
    send_pkt(40, 32'h200, 1'b1, 1'b0);
    send_pkt(30, 32'h201, 1'b0, 1'b0);
    send_pkt(20, 32'h202, 1'b1, 1'b0);
    exp_drops++;
    check("ovf_drop", 80'(drop_count), 80'(exp_drops));
    net_in_ready = 1'b1;
    drain("ovf_stream");

    // Packet-slot overflow: nine 1-flit packets, ninth dropped
    net_in_ready = 1'b0;
    for (int p = 0; p < 9; p++) send_pkt(1, 32'(32'h300 + p), (p < PKT_DEPTH), 1'b0);
    exp_drops++;
    tick();
    check("slot_drop", 80'(drop_count), 80'(exp_drops));
    net_in_ready = 1'b1;
    drain("slot_stream");

    // Randomized traffic, admitted only when it must fit without drops
    rdy_random = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      int c;
      len = $urandom_range(1, 24);
      c = 0;
      while (((exp_q.size() - rx_q.size()) + len > DEPTH || (exp_lasts - rx_lasts) >= PKT_DEPTH) && c < 3000) begin
        tick();
        c++;
      end
      if (c >= 3000) check("rand_admit_timeout", 80'(c), 80'(0));
      send_pkt(len, 32'(32'h400 + p), 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("rand_stream");
    rdy_random = 1'b0;
    net_in_ready = 1'b1;
    check("rand_drop", 80'(drop_count), 80'(exp_drops));

    // Reset mid-packet with a flit parked in the output register
    net_in_ready = 1'b0;
    send_pkt(1, 32'h500, 1'b0, 1'b0);
    tick();
    check("pre_rst_valid", 80'(net_in_valid), 80'(1));
    send_flit(64'h5010, 8'hFF, 1'b0);
    send_flit(64'h5011, 8'hFF, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_ready", 80'(net_out_ready), 80'(0));
    check("mid_rst_in_valid", 80'(net_in_valid), 80'(0));
    check("mid_rst_bits", 80'({net_in_bits_data, net_in_bits_keep, net_in_bits_last}), 80'(0));
    check("mid_rst_drop", 80'(drop_count), 80'(0));
    exp_drops = 0;
    end_send();
    rx_q.delete();
    exp_q.delete();
    rx_lasts  = 0;
    exp_lasts = 0;
    tick();
    tick();
    release_reset();
    net_in_ready = 1'b1;
    send_pkt(2, 32'h600, 1'b1, 1'b0);
    drain("post_rst_stream");
    check("post_rst_drop", 80'(drop_count), 80'(exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_loopback.md
NET_LOOPBACK -- requirements
Module: net_loopback

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning flit-buffer entries (power of 2, >=4).
REQ-002 SHALL have parameter PKT_DEPTH, default 8, meaning max packets resident (committed, not fully sent).
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports net_out_valid in 1, net_out_ready out 1, net_out_bits_data in 64, net_out_bits_keep in 8, net_out_bits_last in 1: NIC-transmit stream sunk by this block.
REQ-006 SHALL have ports net_in_valid out 1, net_in_ready in 1, net_in_bits_data out 64, net_in_bits_keep out 8, net_in_bits_last out 1: NIC-receive stream sourced by this block.
REQ-007 SHALL have port drop_count  output  16  count of dropped packets, saturating at 16'hFFFF.

Function
REQ-008 SHALL act as a store-and-forward loopback: packets accepted on net_out_* SHALL be replayed on net_in_* unmodified (data, keep, last), in order, whole packets only.
REQ-009 SHALL store flits in a DEPTH-entry RAM {data,keep,last} with wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-010 SHALL define occupancy = wr_ptr - rd_ptr; full when occupancy == DEPTH.
REQ-011 SHALL hold net_out_ready registered; 0 in reset, 1 from first clock edge after reset deassertion; never deasserted otherwise (overflow handled by drop, not backpressure).
REQ-012 SHALL implement receive FSM states RX_ACCEPT, RX_DROP; reset state RX_ACCEPT.
REQ-013 RX_ACCEPT, handshake, RAM not full, not last: write flit, wr_ptr+1.
REQ-014 RX_ACCEPT, handshake, last, RAM not full, pkt_count < PKT_DEPTH: write flit, commit_ptr <= wr_ptr+1, wr_ptr+1, pkt_count+1.
REQ-015 RX_ACCEPT, handshake, RAM full, or last with pkt_count == PKT_DEPTH: discard flit, wr_ptr <= commit_ptr, drop_count+1; go RX_DROP unless flit is last (stay RX_ACCEPT).
REQ-016 RX_DROP: discard all flits; on last-flit handshake return to RX_ACCEPT; drop_count unchanged.
REQ-017 Packets longer than DEPTH flits SHALL always be dropped; no partial packet SHALL ever reach net_in_*.
REQ-018 SHALL have one output register; load from RAM[rd_ptr], rd_ptr+1, when rd_ptr != commit_ptr and (net_in_valid==0 or net_in_ready==1).
REQ-019 Latency: commit_ptr updates at edge E; first flit valid on net_in_* after edge E+1; with net_in_ready held 1, one flit per cycle.
REQ-020 While net_in_valid && !net_in_ready, all net_in_bits_* SHALL hold stable.
REQ-021 pkt_count SHALL decrement on net_in handshake with net_in_bits_last=1; simultaneous commit and decrement leaves it unchanged.
REQ-022 Simultaneous RAM write and read in one cycle SHALL both take effect; full check uses pre-edge occupancy.

Reset
REQ-023 Reset SHALL asynchronously clear pointers, pkt_count, drop_count, FSM (RX_ACCEPT), net_out_ready, net_in_valid, net_in_bits_data/keep/last to 0.
REQ-024 Reset mid-packet SHALL discard all buffered and partial packets; RAM contents need not be cleared.

Verification
REQ-025 One 3-flit packet data 0x11,0x22,0x33, keep 8'hFF, net_in_ready=1 -> same three flits on consecutive cycles, last on 0x33, first valid after edge E+1.
REQ-026 Same packet, net_in_ready=0 for 10 cycles after valid -> flit 0x11 held stable 10 cycles, then 0x22,0x33 on release; drop_count=0.
REQ-027 DEPTH=64, net_in_ready=0: 40-flit, then 30-flit, then 20-flit packets -> 30-flit dropped, drop_count=1; release -> 40 then 20 flits out.
REQ-028 65-flit packet -> dropped, drop_count=1, net_in_valid stays 0; next 2-flit packet delivered intact.
REQ-029 net_in_ready=0, nine 1-flit packets, PKT_DEPTH=8 -> ninth dropped, drop_count=1; release -> eight packets out.
REQ-030 Reset asserted after 2 of 4 flits, mid-cycle -> all outputs 0 immediately; after release, new 2-flit packet delivered with no stale flits.
